// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error
// flags and a choice of first-word-fall-through or registered read.
module sync_fifo_flags #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 2**ADDR_W - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] w_data,
    input  logic              we,
    output logic              full,
    output logic              almost_full,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    input  logic              re,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH %0d outside 1..%0d", AF_THRESH, DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH %0d outside 0..%0d", AE_THRESH, DEPTH - 1);
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              rd_acc;
    logic              wr_acc;

    // A full FIFO may take a write only when a word leaves in the same cycle;
    // an empty FIFO never forwards a same-cycle write to the reader.
    assign rd_acc = re & (count_q != '0);
    assign wr_acc = we & ((count_q != DEPTH_C) | rd_acc);

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_ff @(posedge clk) begin
        if (!rst && ce && wr_acc) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (ce) begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + (ADDR_W+1)'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - (ADDR_W+1)'(1);
            end
            // Set beats clear when both happen in one cycle.
            overflow_q  <= (overflow_q  & ~clr_err) | (we & ~wr_acc);
            underflow_q <= (underflow_q & ~clr_err) | (re & ~rd_acc);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign r_data  = empty ? '0 : mem[rd_ptr];
        assign r_valid = ~empty;
    end else begin : g_reg_read
        logic [DATA_W-1:0] r_data_q;
        logic              r_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else if (ce) begin
                if (rd_acc) r_data_q <= mem[rd_ptr];
                r_valid_q <= rd_acc;
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end

endmodule
